// File: rtl/ercm_mul_arb.sv
// Round-robin arbiter sharing one approximate 8x8 multiplier among four requesters.
// Latency 2 cycles accept->rsp_vld; rsp_rdy low stalls the pipe, req_rdy drops once both stages are full.
module ercm_mul_arb #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int MASKW = 7,
    parameter int CNTW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_vld,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_rdy,
    input  logic              cfg_we,
    input  logic [IDW-1:0]    cfg_id,
    input  logic [MASKW-1:0]  cfg_mask,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    output logic [MASKW-1:0]  mul_mask,
    input  logic [15:0]       mul_p,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [15:0]       rsp_dat,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy,
    output logic [CNTW-1:0]   rsp_cnt
);

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   idx;
    logic             win_vld;
    logic             s1_vld;
    logic [IDW-1:0]   s1_id;
    logic             s1_go;
    logic             s2_go;
    logic             accept;
    logic [MASKW-1:0] mask_reg [NREQ];

    assign s2_go  = ~rsp_vld | rsp_rdy;
    assign s1_go  = ~s1_vld | s2_go;
    assign accept = win_vld & s1_go & ~rst;
    assign busy   = s1_vld | rsp_vld;

    // First requester at or after the pointer wins, wrapping past the top index.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + IDW'(i);
            if (!win_vld && req_vld[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        if (win_vld) req_rdy[win] = s1_go & ~rst;
    end

    // Mask is read before this cycle's write lands, so an accept sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) mask_reg[i] <= '0;
        end else if (cfg_we) begin
            mask_reg[cfg_id] <= cfg_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            s1_vld   <= 1'b0;
            s1_id    <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_mask <= '0;
            rsp_vld  <= 1'b0;
            rsp_dat  <= '0;
            rsp_id   <= '0;
            rsp_cnt  <= '0;
        end else begin
            if (accept) begin
                ptr      <= win + IDW'(1);
                mul_a    <= req_a[8*win +: 8];
                mul_b    <= req_b[8*win +: 8];
                mul_mask <= mask_reg[win];
                s1_id    <= win;
            end
            if (s1_go) s1_vld <= accept;
            if (s2_go) begin
                rsp_vld <= s1_vld;
                if (s1_vld) begin
                    rsp_dat <= mul_p;
                    rsp_id  <= s1_id;
                end
            end
            if (rsp_vld && rsp_rdy) rsp_cnt <= rsp_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_ercm_mul_arb.sv
// Bench for ercm_mul_arb: directed scenarios plus random traffic against a queue-based reference model.
module tb_ercm_mul_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_vld;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_rdy;
    logic        cfg_we;
    logic [1:0]  cfg_id;
    logic [6:0]  cfg_mask;
    logic [7:0]  mul_a, mul_b;
    logic [6:0]  mul_mask;
    logic [15:0] mul_p;
    logic        rsp_vld, rsp_rdy;
    logic [15:0] rsp_dat;
    logic [1:0]  rsp_id;
    logic        busy;
    logic [15:0] rsp_cnt;

    always #5 clk = ~clk;

    ercm_mul_arb dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_a(req_a), .req_b(req_b),
        .req_rdy(req_rdy), .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_mask(cfg_mask),
        .mul_a(mul_a), .mul_b(mul_b), .mul_mask(mul_mask), .mul_p(mul_p),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dat(rsp_dat), .rsp_id(rsp_id),
        .busy(busy), .rsp_cnt(rsp_cnt)
    );

    // Stand-in approximate multiplier: exact product with masked low bits cleared.
    function automatic logic [15:0] amul(input logic [7:0] a, input logic [7:0] b, input logic [6:0] m);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        return p & ~{9'b0, m};
    endfunction

    assign mul_p = amul(mul_a, mul_b, mul_mask);

    typedef struct {
        logic [1:0] id;
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] m;
        bit         at_rsp;
    } op_t;

    op_t         q[$];
    int          ptr;
    logic [6:0]  mk[4];
    logic [15:0] cnt;
    logic [7:0]  ma, mb;
    logic [6:0]  mm;
    int          n_acc;
    int          vectors = 0;
    int          errors  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        ptr = 0;
        for (int i = 0; i < 4; i++) mk[i] = '0;
        cnt = '0; ma = '0; mb = '0; mm = '0; n_acc = 0;
    endtask

    task automatic do_reset();
        req_vld = '0; rsp_rdy = 1'b1; cfg_we = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);
        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_mul_a",   32'(mul_a),   32'd0);
        chk("rst_mul_b",   32'(mul_b),   32'd0);
        chk("rst_mul_mask",32'(mul_mask),32'd0);
        chk("rst_rsp_dat", 32'(rsp_dat), 32'd0);
        chk("rst_rsp_id",  32'(rsp_id),  32'd0);
        chk("rst_rsp_cnt", 32'(rsp_cnt), 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Check one cycle against the model, then advance the model across the clock edge.
    task automatic step();
        int  win;
        bit  found, can, ev;
        op_t o;
        #1;
        found = 0; win = 0;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (ptr + i) % 4;
            if (!found && req_vld[k]) begin found = 1; win = k; end
        end
        can = !(q.size() == 2 && !rsp_rdy);
        ev  = q.size() > 0 && q[0].at_rsp;
        chk("req_rdy", 32'(req_rdy), (found && can) ? (32'd1 << win) : 32'd0);
        chk("rsp_vld", 32'(rsp_vld), 32'(ev));
        chk("busy",    32'(busy),    32'(q.size() > 0));
        if (ev) begin
            chk("rsp_dat", 32'(rsp_dat), 32'(amul(q[0].a, q[0].b, q[0].m)));
            chk("rsp_id",  32'(rsp_id),  32'(q[0].id));
        end
        chk("mul_a",    32'(mul_a),    32'(ma));
        chk("mul_b",    32'(mul_b),    32'(mb));
        chk("mul_mask", 32'(mul_mask), 32'(mm));
        chk("rsp_cnt",  32'(rsp_cnt),  32'(cnt));
        if (ev && rsp_rdy) begin
            void'(q.pop_front());
            cnt = cnt + 16'd1;
        end
        if (q.size() > 0 && !q[0].at_rsp) q[0].at_rsp = 1;
        if (found && can) begin
            o.id = 2'(win); o.a = req_a[8*win +: 8]; o.b = req_b[8*win +: 8];
            o.m = mk[win]; o.at_rsp = 0;
            q.push_back(o);
            ma = o.a; mb = o.b; mm = o.m;
            ptr = (win + 1) % 4;
            n_acc++;
        end
        if (cfg_we) mk[cfg_id] = cfg_mask;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int nacc;
        req_a = '0; req_b = '0; cfg_id = '0; cfg_mask = '0;
        do_reset();

        // Single request from requester 0.
        req_vld = 4'b0001; req_a = 32'd13; req_b = 32'd11; rsp_rdy = 1'b1;
        #1 chk("single_rdy", 32'(req_rdy), 32'd1);
        step();
        req_vld = '0;
        step();
        chk("single_vld", 32'(rsp_vld), 32'd1);
        chk("single_id",  32'(rsp_id),  32'd0);
        chk("single_dat", 32'(rsp_dat), 32'd143);
        step();
        chk("single_cnt", 32'(rsp_cnt), 32'd1);

        // Round robin with everyone requesting.
        do_reset();
        req_vld = 4'hF; req_a = $urandom; req_b = $urandom;
        for (int i = 0; i < 8; i++) begin
            #1 chk("rr_grant", 32'(req_rdy), 32'd1 << (i % 4));
            step();
        end
        req_vld = '0;
        repeat (3) step();
        chk("rr_cnt", 32'(rsp_cnt), 32'd8);
        req_vld = 4'hF;
        #1 chk("rr_ptr_end", 32'(req_rdy), 32'd1);
        req_vld = '0;

        // Backpressure: two ops fill the pipe, then accepts stop.
        do_reset();
        rsp_rdy = 1'b0; req_vld = 4'hF; req_a = $urandom; req_b = $urandom;
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            #1 if (req_rdy != 4'b0) nacc++;
            step();
        end
        chk("bp_accepts", 32'(nacc), 32'd2);
        rsp_rdy = 1'b1; req_vld = '0;
        repeat (4) step();
        chk("bp_cnt", 32'(rsp_cnt), 32'd2);

        // Mask write in the same cycle requester 2 is accepted.
        do_reset();
        req_vld = 4'b0100; req_a = $urandom; req_b = $urandom;
        cfg_we = 1'b1; cfg_id = 2'd2; cfg_mask = 7'h55;
        step();
        cfg_we = 1'b0;
        chk("mask_old", 32'(mul_mask), 32'd0);
        step();
        chk("mask_new", 32'(mul_mask), 32'h55);
        req_vld = '0;
        repeat (3) step();

        // Reset with both stages occupied.
        do_reset();
        rsp_rdy = 1'b0; req_vld = 4'hF; req_a = $urandom | 32'h0101_0101; req_b = $urandom;
        repeat (3) step();
        chk("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("mid_req_rdy", 32'(req_rdy), 32'd0);
        chk("mid_busy0",   32'(busy),    32'd0);
        chk("mid_mul_a",   32'(mul_a),   32'd0);
        chk("mid_mul_b",   32'(mul_b),   32'd0);
        chk("mid_rsp_dat", 32'(rsp_dat), 32'd0);
        chk("mid_rsp_cnt", 32'(rsp_cnt), 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0; rsp_rdy = 1'b1; req_vld = '0;
        repeat (4) step();
        chk("mid_no_stale", 32'(rsp_cnt), 32'd0);

        // Random traffic with random backpressure and mask writes.
        for (int i = 0; i < 3000; i++) begin
            req_vld  = 4'($urandom_range(0, 15));
            req_a    = $urandom;
            req_b    = $urandom;
            rsp_rdy  = ($urandom_range(0, 3) != 0);
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_id   = 2'($urandom_range(0, 3));
            cfg_mask = 7'($urandom_range(0, 127));
            step();
        end
        cfg_we = 1'b0; req_vld = '0; rsp_rdy = 1'b1;
        repeat (4) step();

        // Counter wrap after 65536 deliveries.
        do_reset();
        req_vld = 4'hF; rsp_rdy = 1'b1;
        while (n_acc < 65536) begin
            req_a = $urandom; req_b = $urandom;
            step();
        end
        req_vld = '0;
        repeat (3) step();
        chk("cnt_wrap", 32'(rsp_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
